sw_req_tx: RTL and testbench



---
 rtl/sw_req_tx.sv | 214 +++++++++++++++++++++
 tb/tb_sw_req_tx.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_req_tx.sv
// Transmit side of the switch-instance access path: decodes one host request, issues a
// one-hot select and, for reads, waits for ack or timeout. Optional error counter: SW_REQ_TX_ERR_CNT_EN.
module sw_req_tx #(
  parameter int NUM_SW_INST    = 5,
  parameter int W_WIDTH        = 8,
  parameter int A_WIDTH        = 8,
  parameter int OFFS_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [A_WIDTH-1:0]     req_addr,
  input  logic [W_WIDTH-1:0]     req_wdata,
  input  logic [NUM_SW_INST-1:0] sw_busy,
  input  logic [NUM_SW_INST-1:0] ack,
`ifdef SW_REQ_TX_ERR_CNT_EN
  input  logic                   err_cnt_clr,
  output logic [7:0]             err_cnt,
`endif
  output logic [NUM_SW_INST-1:0] sel_en,
  output logic                   wr_en,
  output logic [OFFS_WIDTH-1:0]  addr_out,
  output logic [W_WIDTH-1:0]     wr_data_out,
  output logic                   done,
  output logic                   err
);

  localparam int IDX_WIDTH = A_WIDTH - OFFS_WIDTH;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_FREE,
    S_ISSUE,
    S_WAIT_ACK
  } state_e;

  state_e                 state_q, state_d;
  logic                   wr_q, wr_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [OFFS_WIDTH-1:0]  offs_q, offs_d;
  logic [W_WIDTH-1:0]     wdata_q, wdata_d;
  logic [7:0]             cnt_q, cnt_d;

  logic                   req_ready_q, req_ready_d;
  logic [NUM_SW_INST-1:0] sel_en_q, sel_en_d;
  logic                   wr_en_q, wr_en_d;
  logic [OFFS_WIDTH-1:0]  addr_out_q, addr_out_d;
  logic [W_WIDTH-1:0]     wr_data_out_q, wr_data_out_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [NUM_SW_INST-1:0] inst_oh;
  logic                   busy_hit;
  logic                   ack_hit;

  // An all-zero decode means the index names no instance (decode miss).
  always_comb begin
    inst_oh = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      inst_oh[i] = (idx_q == IDX_WIDTH'(i));
    end
  end

  assign busy_hit = |(sw_busy & inst_oh);
  assign ack_hit  = |(ack & inst_oh);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    idx_d         = idx_q;
    offs_d        = offs_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    sel_en_d      = '0;
    wr_en_d       = 1'b0;
    addr_out_d    = addr_out_q;
    wr_data_out_d = wr_data_out_q;
    done_d        = 1'b0;
    err_d         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          idx_d   = req_addr[A_WIDTH-1:OFFS_WIDTH];
          offs_d  = req_addr[OFFS_WIDTH-1:0];
          wdata_d = req_wdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (inst_oh == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (busy_hit) begin
          cnt_d   = '0;
          state_d = S_WAIT_FREE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_FREE: begin
        if (!busy_hit) begin
          state_d = S_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ISSUE: begin
        sel_en_d      = inst_oh;
        wr_en_d       = wr_q;
        addr_out_d    = offs_q;
        wr_data_out_d = wr_q ? wdata_q : '0;
        if (wr_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // Ack is tested before the timeout so a same-cycle ack still completes cleanly.
        if (ack_hit) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_q          <= 1'b0;
      idx_q         <= '0;
      offs_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      sel_en_q      <= '0;
      wr_en_q       <= 1'b0;
      addr_out_q    <= '0;
      wr_data_out_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      idx_q         <= idx_d;
      offs_q        <= offs_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      sel_en_q      <= sel_en_d;
      wr_en_q       <= wr_en_d;
      addr_out_q    <= addr_out_d;
      wr_data_out_q <= wr_data_out_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign sel_en      = sel_en_q;
  assign wr_en       = wr_en_q;
  assign addr_out    = addr_out_q;
  assign wr_data_out = wr_data_out_q;
  assign done        = done_q;
  assign err         = err_q;

`ifdef SW_REQ_TX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Clear takes priority over a same-cycle error; the count saturates at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sw_req_tx.sv
// Self-checking bench for sw_req_tx: directed scenarios plus randomized requests scored
// against a per-request timeline model. Error-counter checks build when SW_REQ_TX_ERR_CNT_EN is defined.
module tb_sw_req_tx;

  localparam int N  = 5;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [4:0] sw_busy = '0;
  logic [4:0] ack = '0;
  logic       err_cnt_clr = 1'b0;
  logic [7:0] err_cnt;
  logic [4:0] sel_en;
  logic       wr_en;
  logic [3:0] addr_out;
  logic [7:0] wr_data_out;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  // Per-edge input traces for one request; index = edges after the accept edge.
  logic [4:0] busy_tr [0:39];
  logic [4:0] ack_tr  [0:39];

  logic [3:0] exp_addr  = '0;
  logic [7:0] exp_wdata = '0;
  int         exp_err_cnt = 0;

  sw_req_tx dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .sw_busy     (sw_busy),
    .ack         (ack),
`ifdef SW_REQ_TX_ERR_CNT_EN
    .err_cnt_clr (err_cnt_clr),
    .err_cnt     (err_cnt),
`endif
    .sel_en      (sel_en),
    .wr_en       (wr_en),
    .addr_out    (addr_out),
    .wr_data_out (wr_data_out),
    .done        (done),
    .err         (err)
  );

`ifndef SW_REQ_TX_ERR_CNT_EN
  assign err_cnt = '0;
`endif

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_traces();
    for (int i = 0; i < 40; i++) begin
      busy_tr[i] = '0;
      ack_tr[i]  = '0;
    end
  endtask

  // Drives one request from IDLE and compares every output on every edge until one cycle after completion.
  task automatic run_req(input logic wr, input logic [7:0] addr, input logic [7:0] wdata, input string name);
    int         idx;
    int         sel_e;
    int         end_e;
    logic       end_err;
    int         t;
    logic [4:0] oh;
    logic [4:0] exp_sel;

    idx     = int'(addr[7:4]);
    sel_e   = -1;
    end_err = 1'b0;
    oh      = 5'b00001 << idx;

    // Reference timeline: first free edge issues next edge; read then waits up to TO edges for its ack.
    if (idx >= N) begin
      end_e   = 1;
      end_err = 1'b1;
    end else begin
      t = 1;
      while (t <= TO + 1 && busy_tr[t][idx]) t++;
      if (t > TO + 1) begin
        end_e   = TO + 1;
        end_err = 1'b1;
      end else begin
        sel_e = t + 1;
        if (wr) begin
          end_e = sel_e;
        end else begin
          end_e   = sel_e + TO;
          end_err = 1'b1;
          for (int j = 1; j <= TO; j++) begin
            if (ack_tr[sel_e + j][idx]) begin
              end_e   = sel_e + j;
              end_err = 1'b0;
              break;
            end
          end
        end
      end
    end

    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready_before_accept got %b exp 1", name, req_ready);
    end

    for (int e = 0; e <= end_e + 1; e++) begin
      if (e == 0) begin
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        sw_busy   = busy_tr[0];
        ack       = '0;
      end else begin
        req_valid = 1'b0;
        req_wr    = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
        sw_busy   = busy_tr[e];
        ack       = ack_tr[e];
      end
      step();

      if (e == sel_e) begin
        exp_addr  = addr[3:0];
        exp_wdata = wr ? wdata : 8'h00;
      end
      if (e == end_e && end_err && exp_err_cnt < 255) exp_err_cnt++;
      exp_sel = (e == sel_e) ? oh : 5'b00000;

      checks++;
      if (sel_en !== exp_sel) begin
        errors++;
        $display("FAIL %s t=%0d sel_en got %b exp %b", name, e, sel_en, exp_sel);
      end
      checks++;
      if (wr_en !== (e == sel_e && wr)) begin
        errors++;
        $display("FAIL %s t=%0d wr_en got %b exp %b", name, e, wr_en, (e == sel_e && wr));
      end
      checks++;
      if (done !== (e == end_e && !end_err)) begin
        errors++;
        $display("FAIL %s t=%0d done got %b exp %b", name, e, done, (e == end_e && !end_err));
      end
      checks++;
      if (err !== (e == end_e && end_err)) begin
        errors++;
        $display("FAIL %s t=%0d err got %b exp %b", name, e, err, (e == end_e && end_err));
      end
      checks++;
      if (req_ready !== (e >= end_e)) begin
        errors++;
        $display("FAIL %s t=%0d req_ready got %b exp %b", name, e, req_ready, (e >= end_e));
      end
      checks++;
      if (addr_out !== exp_addr || wr_data_out !== exp_wdata) begin
        errors++;
        $display("FAIL %s t=%0d addr/data got %h/%h exp %h/%h", name, e, addr_out, wr_data_out, exp_addr, exp_wdata);
      end
`ifdef SW_REQ_TX_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'(exp_err_cnt)) begin
        errors++;
        $display("FAIL %s t=%0d err_cnt got %0d exp %0d", name, e, err_cnt, exp_err_cnt);
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({sel_en, wr_en, addr_out, wr_data_out, done, err, req_ready} !== {5'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values got sel=%b wr_en=%b addr=%h data=%h done=%b err=%b rdy=%b exp all 0 rdy=1",
               sel_en, wr_en, addr_out, wr_data_out, done, err, req_ready);
    end
`ifdef SW_REQ_TX_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_err_cnt got %0d exp 0", err_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_free();
    clear_traces();
    run_req(1'b1, 8'h25, 8'hA5, "write_free");
  endtask

  task automatic test_read_ack();
    clear_traces();
    ack_tr[6] = 5'b00010;
    run_req(1'b0, 8'h13, 8'h77, "read_ack");
  endtask

  task automatic test_decode_miss();
    clear_traces();
    run_req(1'b1, 8'h70, 8'h11, "decode_miss");
  endtask

  task automatic test_busy_timeout();
    clear_traces();
    for (int i = 0; i < 40; i++) busy_tr[i] = 5'b00100;
    run_req(1'b1, 8'h20, 8'h5A, "busy_timeout");
  endtask

  task automatic test_busy_release();
    clear_traces();
    for (int i = 0; i <= 5; i++) busy_tr[i] = 5'b00100;
    run_req(1'b1, 8'h2C, 8'h3C, "busy_release");
  endtask

  task automatic test_read_timeout();
    clear_traces();
    ack_tr[4] = 5'b01000;
    ack_tr[9] = 5'b01000;
    run_req(1'b0, 8'h07, 8'h00, "read_timeout");
  endtask

  task automatic test_back_to_back();
    clear_traces();
    run_req(1'b1, 8'h41, 8'hC3, "b2b_0");
    run_req(1'b1, 8'h0E, 8'h3C, "b2b_1");
    ack_tr[3] = 5'b01000;
    run_req(1'b0, 8'h3F, 8'h99, "b2b_2");
  endtask

  task automatic test_reset_mid_wait_ack();
    clear_traces();
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 8'h13;
    req_wdata = 8'h00;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2;
    rst = 1'b1;
    #1;
    exp_addr    = '0;
    exp_wdata   = '0;
    exp_err_cnt = 0;
    checks++;
    if ({sel_en, wr_en, addr_out, wr_data_out, done, err, req_ready} !== {5'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid got sel=%b wr_en=%b addr=%h data=%h done=%b err=%b rdy=%b exp all 0 rdy=1",
               sel_en, wr_en, addr_out, wr_data_out, done, err, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    ack = 5'b00010;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1 || sel_en !== 5'b0) begin
        errors++;
        $display("FAIL reset_mid_after c=%0d done=%b err=%b rdy=%b sel=%b exp 0 0 1 0", i, done, err, req_ready, sel_en);
      end
    end
    ack = '0;
  endtask

`ifdef SW_REQ_TX_ERR_CNT_EN
  task automatic test_err_cnt();
    clear_traces();
    for (int i = 0; i < 3; i++) run_req(1'b0, 8'h90, 8'h00, "err_cnt_miss");
    checks++;
    if (err_cnt !== 8'd3) begin
      errors++;
      $display("FAIL err_cnt_three got %0d exp 3", err_cnt);
    end
    err_cnt_clr = 1'b1;
    step();
    err_cnt_clr = 1'b0;
    exp_err_cnt = 0;
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL err_cnt_clear got %0d exp 0", err_cnt);
    end
    for (int i = 0; i < 257; i++) run_req(1'b1, 8'hF0, 8'h00, "err_cnt_sat");
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL err_cnt_saturate got %0d exp 255", err_cnt);
    end
    err_cnt_clr = 1'b1;
    step();
    err_cnt_clr = 1'b0;
    exp_err_cnt = 0;
  endtask
`endif

  task automatic test_random();
    logic [7:0] addr;
    int         idx;
    int         rel;
    for (int n = 0; n < 40; n++) begin
      addr = 8'($urandom_range(0, 8'h7F));
      idx  = int'(addr[7:4]);
      rel  = $urandom_range(0, 20);
      for (int i = 0; i < 40; i++) begin
        busy_tr[i] = 5'($urandom);
        ack_tr[i]  = 5'($urandom);
        if (idx < N) begin
          busy_tr[i][idx] = (i < rel);
          ack_tr[i][idx]  = ($urandom_range(0, 9) == 0);
        end
      end
      run_req(1'($urandom), addr, 8'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_free();
    test_read_ack();
    test_decode_miss();
    test_busy_timeout();
    test_busy_release();
    test_read_timeout();
    test_back_to_back();
    test_reset_mid_wait_ack();
`ifdef SW_REQ_TX_ERR_CNT_EN
    test_err_cnt();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
